link_rx: RTL and testbench

- Serial receiver for the board-to-board game link.
- The peer board drives its JA[0] as a UART-style frame stream, wired to our JB[0]. This block recovers bytes from that stream (e.g. start/player/move messages) and hands them to the menu/game logic.
- It also flags parity and framing errors and maintains a link-alive indicator.
- It sits on the 100 MHz `clock` domain beside the menu and game logic.

---
 rtl/link_rx.sv | 188 ++++++++++++++++++
 tb/tb_link_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/link_rx.sv
// link_rx: UART-style receiver for the board-to-board game link (8E1 frames)
// Ports: clock/reset_n, rx_in serial line; rx_data/rx_valid, error pulses, busy, link_up
module link_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int TIMEOUT_CLKS = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic       link_up
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TM1  = TW'(TIMEOUT_CLKS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BRK    = 3'd5;

  logic          s1_q, s2_q, prev_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          link_q, link_d;
  logic          bit_end;

  // Synchronizer idles high so reset release never looks like a start edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= rx_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!s2_q) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d       = '0;
          sh_d[idx_q] = s2_q;
          if (idx_q == 3'd7) state_d = PARITY;
          else idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          par_d   = s2_q;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (s2_q) begin
            state_d = IDLE;
            if (^{sh_q, par_q} == 1'b0) begin
              data_d = sh_q;
              vld_d  = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
          end else begin
            // Low stop bit: wait out a held-low line in BRK
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BRK: begin
        cnt_d = '0;
        if (s2_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Watchdog: only good frames refresh it; counter saturates
  always_comb begin
    tmo_d  = tmo_q;
    link_d = link_q;
    if (vld_q) begin
      tmo_d  = '0;
      link_d = 1'b1;
    end else begin
      if (tmo_q != TMAX) tmo_d = tmo_q + 1'b1;
      if (tmo_q == TM1) link_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      tmo_q   <= '0;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      tmo_q   <= tmo_d;
      link_q  <= link_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = vld_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);
  assign link_up    = link_q;

endmodule

// File: tb/tb_link_rx.sv
// tb_link_rx: randomized frame stimulus against a frame-level reference model
// Drives 8E1 frames into link_rx and compares pulses, data and link_up
module tb_link_rx;

  localparam int CPB = 16;
  localparam int TMO = 2000;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic       link_up;

  link_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .rx_in(rx_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .busy(busy),
    .link_up(link_up)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        obs[$];
  ev_t        expq[$];
  int         cyc = 0;
  int         first_cyc = -1;
  int         last_vld = -1;
  int         t0 = 0;
  int         pass = 0;
  int         total = 0;
  bit         busy_seen = 0;
  bit         prev_vld = 0;
  logic [7:0] exp_data = 8'h00;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got == want) pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  // Output monitor: samples 1 time unit after each rising edge
  always begin
    @(posedge clock);
    cyc++;
    #1;
    if (busy) busy_seen = 1;
    if (prev_vld) check("link_after_vld", link_up, 1);
    prev_vld = rx_valid;
    if (rx_valid || parity_err || frame_err) begin
      check("excl", rx_valid + parity_err + frame_err, 1);
      if (rx_valid) begin
        obs.push_back('{0, rx_data});
        last_vld = cyc;
      end else if (parity_err) obs.push_back('{1, rx_data});
      else obs.push_back('{2, rx_data});
      if (first_cyc < 0) first_cyc = cyc;
    end
  end

  // Frame-level reference: even parity over data, stop bit decides framing
  task automatic expect_frame(input logic [7:0] d, input bit pf, input bit st);
    if (!st) expq.push_back('{2, exp_data});
    else if (pf) expq.push_back('{1, exp_data});
    else begin
      exp_data = d;
      expq.push_back('{0, d});
    end
  endtask

  task automatic align();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pf, input bit st);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit((^d) ^ pf);
    drive_bit(st);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    repeat (40) @(negedge clock);
    check("n_ev", obs.size(), expq.size());
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      check("ev_kind", obs[i].kind, expq[i].kind);
      check("ev_data", obs[i].data, expq[i].data);
    end
    check("rx_data", rx_data, exp_data);
    obs.delete();
    expq.delete();
  endtask

  initial begin
    logic [7:0] d;
    bit         pf;
    bit         st;
    int         lat;
    int         v;

    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(500);
    check("rst_data", rx_data, 0);
    check("rst_link", link_up, 0);
    check("rst_busy_seen", busy_seen, 0);
    check("rst_pulses", obs.size(), 0);

    first_cyc = -1;
    expect_frame(8'hA5, 0, 1);
    send_frame(8'hA5, 0, 1);
    idle(10);
    lat = (first_cyc < 0) ? -1 : first_cyc - t0;
    check("latency_ok", (lat >= 170 && lat <= 172), 1);
    drain();
    check("link_a5", link_up, 1);

    align();
    expect_frame(8'h3C, 0, 1);
    expect_frame(8'h81, 0, 1);
    send_frame(8'h3C, 0, 1);
    send_frame(8'h81, 0, 1);
    drain();

    align();
    expect_frame(8'h5A, 1, 1);
    send_frame(8'h5A, 1, 1);
    drain();
    check("link_perr", link_up, 1);

    align();
    expect_frame(8'h11, 0, 0);
    send_frame(8'h11, 0, 0);
    rx_in = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    check("brk_busy", busy, 1);
    idle(10);
    check("brk_release", busy, 0);
    expect_frame(8'h22, 0, 1);
    send_frame(8'h22, 0, 1);
    drain();

    align();
    rx_in = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    idle(40);
    check("glitch_busy", busy, 0);
    drain();

    align();
    for (int k = 0; k < 12; k++) begin
      d  = 8'($urandom_range(0, 255));
      pf = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 5) != 0);
      expect_frame(d, pf, st);
      send_frame(d, pf, st);
      if (!st) begin
        rx_in = 1'b0;
        repeat ($urandom_range(0, 30)) @(posedge clock);
        #1;
        idle(20);
      end else begin
        idle($urandom_range(0, 20));
      end
    end
    drain();

    align();
    expect_frame(8'h77, 0, 1);
    send_frame(8'h77, 0, 1);
    drain();
    v = last_vld;
    while (cyc < v + TMO - 1) @(negedge clock);
    check("link_before_tmo", link_up, 1);
    while (cyc < v + TMO + 2) @(negedge clock);
    check("link_after_tmo", link_up, 0);
    while (cyc < v + TMO + 500) @(negedge clock);
    check("link_stays_low", link_up, 0);

    align();
    fork
      send_frame(8'hC3, 0, 1);
      begin
        repeat (60) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_vld", rx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_link", link_up, 0);
      end
    join
    idle(20);
    reset_n = 1'b1;
    exp_data = 8'h00;
    idle(300);
    drain();
    check("post_rst_link", link_up, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
